mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: max consecutive MEM grants while IF_Req is held before IF is forced (range 1..15).
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 IF_Req  input  1  fetch read request; IF_Addr  input  32  fetch byte address.
REQ-005 IF_Gnt  output  1  fetch owns RAM port this cycle; IF_Stall  output  1  = IF_Req & ~IF_Gnt.
REQ-006 IF_RdValid  output  1  fetch read data valid; IF_RdData  output  32  fetch read data.
REQ-007 MEM_Req  input  1  data access request; MEM_Write  input  1  1 = store, 0 = load.
REQ-008 MEM_Addr  input  32  data byte address; MEM_WData  input  32  store data.
REQ-009 MEM_Gnt  output  1  data access owns port; MEM_Stall  output  1  = MEM_Req & ~MEM_Gnt.
REQ-010 MEM_RdValid  output  1  load data valid; MEM_RdData  output  32  load data.
REQ-011 IF_Flush  input  1  discard any fetch response returning this cycle.
REQ-012 Mem_Address  output  32  RAM byte address; Mem_MemWrite  output  1  RAM write strobe.
REQ-013 Mem_WriteData  output  32  RAM write data; Mem_ReadData  input  32  RAM read data, valid the cycle after its address.

Function
REQ-014 Grant SHALL be combinational per cycle; at most one of IF_Gnt/MEM_Gnt high.
REQ-015 Default priority SHALL be MEM over IF when both request.
REQ-016 No request: both grants 0, Mem_MemWrite 0, Mem_Address holds last driven value.
REQ-017 Granted requester's address SHALL drive Mem_Address the same cycle; IF_Addr when IF_Gnt, MEM_Addr when MEM_Gnt.
REQ-018 Mem_MemWrite SHALL be MEM_Gnt & MEM_Write; Mem_WriteData SHALL equal MEM_WData.
REQ-019 IF_Gnt SHALL never cause a RAM write.
REQ-020 Response FSM SHALL have states IDLE, IF_RD, MEM_RD; next state = IF_RD if IF_Gnt, MEM_RD if MEM_Gnt & ~MEM_Write, else IDLE.
REQ-021 In IF_RD: IF_RdValid = ~IF_Flush, IF_RdData = Mem_ReadData; in MEM_RD: MEM_RdValid = 1, MEM_RdData = Mem_ReadData.
REQ-022 Read latency SHALL be exactly one cycle from grant to RdValid; back-to-back grants SHALL sustain one access per cycle.
REQ-023 Stores SHALL complete in the grant cycle and SHALL produce no RdValid.
REQ-024 RdData outputs SHALL be 0 whenever the matching RdValid is 0.
REQ-025 IF_Flush SHALL only suppress IF_RdValid; it SHALL NOT affect grants or the FSM.
REQ-026 Simultaneous requests: MEM granted; IF_Stall = 1 that cycle.
REQ-027 Addresses pass unmodified; RAM word select (bits [15:2]) is the RAM's concern.

Reset
REQ-028 While Reset is high: FSM = IDLE, starvation counter = 0, all grants/valids/Mem_MemWrite = 0, RdData = 0, requests ignored.
REQ-029 Reset mid-read SHALL drop the pending response; no RdValid in the cycle after Reset deasserts.
REQ-030 First grant SHALL be possible in the first cycle Reset is low.

Configuration
REQ-031 Macro MEM_ARB_STARVE_GUARD_EN SHALL compile in an anti-starvation counter.
REQ-032 With macro: counter increments on each cycle MEM_Gnt & IF_Req, clears on IF_Gnt or ~IF_Req; at count == STARVE_LIMIT, IF SHALL win the next conflict and the counter clears.
REQ-033 Without macro: strict MEM priority; no counter state exists; IF can stall indefinitely.

Verification
REQ-034 IF_Req held, MEM_Req 0, IF_Addr 0,4,8 -> IF_Gnt 1 each cycle; IF_RdValid one cycle later with RAM words 0,1,2.
REQ-035 MEM load and IF fetch same cycle, MEM_Addr 0x40 -> MEM_Gnt 1, IF_Stall 1; next cycle MEM_RdValid 1 with word 0x10, IF granted.
REQ-036 MEM store 0xDEADBEEF to 0x20 then load 0x20 -> Mem_MemWrite 1 only in store cycle, no RdValid; load returns 0xDEADBEEF.
REQ-037 IF granted, IF_Flush 1 next cycle -> IF_RdValid 0, IF_RdData 0; following fetch returns normally.
REQ-038 With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT 3, MEM_Req and IF_Req held -> 3 MEM grants, 1 IF grant, repeating; without macro -> MEM every cycle.
REQ-039 Reset asserted the cycle after an IF grant -> no IF_RdValid; all outputs 0 during Reset; grant resumes first cycle after.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single RAM port shared by fetch (IF) and data (MEM) with a one-cycle read response FSM.
// Optional MEM_ARB_STARVE_GUARD_EN forces an IF grant after STARVE_LIMIT consecutive MEM wins.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic        IF_Gnt,
  output logic        IF_Stall,
  output logic        IF_RdValid,
  output logic [31:0] IF_RdData,
  input  logic        MEM_Req,
  input  logic        MEM_Write,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  output logic        MEM_Gnt,
  output logic        MEM_Stall,
  output logic        MEM_RdValid,
  output logic [31:0] MEM_RdData,
  input  logic        IF_Flush,
  output logic [31:0] Mem_Address,
  output logic        Mem_MemWrite,
  output logic [31:0] Mem_WriteData,
  input  logic [31:0] Mem_ReadData
);
  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD} state_t;
  state_t state, state_nxt;
  logic [31:0] last_addr;
  logic force_if;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT out of range 1..15");
  end
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  assign force_if = starve_cnt == 4'(STARVE_LIMIT);
  always_ff @(posedge Clock) begin
    if (Reset || IF_Gnt || !IF_Req) starve_cnt <= '0;
    else if (MEM_Gnt) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign force_if = 1'b0;
`endif
  assign IF_Gnt  = !Reset && IF_Req && (!MEM_Req || force_if);
  assign MEM_Gnt = !Reset && MEM_Req && !IF_Gnt;
  assign IF_Stall  = !Reset && IF_Req && !IF_Gnt;
  assign MEM_Stall = !Reset && MEM_Req && !MEM_Gnt;
  // Port address parks on the last granted address when idle.
  assign Mem_Address   = Reset ? 32'd0 : IF_Gnt ? IF_Addr : MEM_Gnt ? MEM_Addr : last_addr;
  assign Mem_MemWrite  = MEM_Gnt && MEM_Write;
  assign Mem_WriteData = Reset ? 32'd0 : MEM_WData;
  always_ff @(posedge Clock) begin
    last_addr <= Mem_Address;
    state <= Reset ? IDLE : state_nxt;
  end
  always_comb begin
    state_nxt = IF_Gnt ? IF_RD : (MEM_Gnt && !MEM_Write) ? MEM_RD : IDLE;
  end
  assign IF_RdValid  = !Reset && state == IF_RD && !IF_Flush;
  assign MEM_RdValid = !Reset && state == MEM_RD;
  assign IF_RdData   = IF_RdValid ? Mem_ReadData : 32'd0;
  assign MEM_RdData  = MEM_RdValid ? Mem_ReadData : 32'd0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, read latency, stores, flush, reset and starvation guard.
module tb_mem_port_arbiter;
  logic        Clock = 0;
  logic        Reset;
  logic        IF_Req, MEM_Req, MEM_Write, IF_Flush;
  logic [31:0] IF_Addr, MEM_Addr, MEM_WData;
  logic        IF_Gnt, IF_Stall, IF_RdValid, MEM_Gnt, MEM_Stall, MEM_RdValid, Mem_MemWrite;
  logic [31:0] IF_RdData, MEM_RdData, Mem_Address, Mem_WriteData, Mem_ReadData;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] ram [0:255];

  mem_port_arbiter #(.STARVE_LIMIT(3)) dut (
    .Clock(Clock), .Reset(Reset),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Gnt(IF_Gnt), .IF_Stall(IF_Stall),
    .IF_RdValid(IF_RdValid), .IF_RdData(IF_RdData),
    .MEM_Req(MEM_Req), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData),
    .MEM_Gnt(MEM_Gnt), .MEM_Stall(MEM_Stall), .MEM_RdValid(MEM_RdValid), .MEM_RdData(MEM_RdData),
    .IF_Flush(IF_Flush), .Mem_Address(Mem_Address), .Mem_MemWrite(Mem_MemWrite),
    .Mem_WriteData(Mem_WriteData), .Mem_ReadData(Mem_ReadData)
  );

  always #5 Clock = ~Clock;

  // Synchronous RAM: word i initialised to i, read data valid the cycle after the address.
  always_ff @(posedge Clock) begin
    if (Mem_MemWrite) ram[Mem_Address[9:2]] <= Mem_WriteData;
    Mem_ReadData <= ram[Mem_Address[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ifr, input logic [31:0] ifa, input logic memr,
                      input logic memw, input logic [31:0] mema, input logic [31:0] wd, input logic fl);
    @(negedge Clock);
    Reset = rst; IF_Req = ifr; IF_Addr = ifa; MEM_Req = memr; MEM_Write = memw;
    MEM_Addr = mema; MEM_WData = wd; IF_Flush = fl;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = i;
    Mem_ReadData = 0;
    step(1, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0);
    step(1, 1, 32'h0, 1, 1, 32'h0, 32'h0, 0);
    chk("rst_if_gnt", IF_Gnt, 0);
    chk("rst_mem_gnt", MEM_Gnt, 0);
    chk("rst_memwrite", Mem_MemWrite, 0);
    chk("rst_if_stall", IF_Stall, 0);
    chk("rst_if_valid", IF_RdValid, 0);
    chk("rst_mem_data", MEM_RdData, 0);
    // Fetch stream 0,4,8
    step(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    chk("f0_gnt", IF_Gnt, 1);
    chk("f0_addr", Mem_Address, 32'h0);
    chk("f0_novalid", IF_RdValid, 0);
    step(0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
    chk("f1_gnt", IF_Gnt, 1);
    chk("f1_valid", IF_RdValid, 1);
    chk("f1_data", IF_RdData, 32'd0);
    step(0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 0);
    chk("f2_valid", IF_RdValid, 1);
    chk("f2_data", IF_RdData, 32'd1);
    step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    chk("idle_gnt", IF_Gnt, 0);
    chk("idle_data", IF_RdData, 32'd2);
    chk("idle_hold_addr", Mem_Address, 32'h8);
    // Conflict: MEM load wins
    step(0, 1, 32'hC, 1, 0, 32'h40, 32'h0, 0);
    chk("cf_mem_gnt", MEM_Gnt, 1);
    chk("cf_if_gnt", IF_Gnt, 0);
    chk("cf_if_stall", IF_Stall, 1);
    chk("cf_addr", Mem_Address, 32'h40);
    chk("cf_if_novalid", IF_RdValid, 0);
    step(0, 1, 32'hC, 0, 0, 32'h0, 32'h0, 0);
    chk("cf2_if_gnt", IF_Gnt, 1);
    chk("cf2_mem_valid", MEM_RdValid, 1);
    chk("cf2_mem_data", MEM_RdData, 32'h10);
    chk("cf2_addr", Mem_Address, 32'hC);
    // Store then load
    step(0, 0, 32'h0, 1, 1, 32'h20, 32'hDEADBEEF, 0);
    chk("st_memwrite", Mem_MemWrite, 1);
    chk("st_wdata", Mem_WriteData, 32'hDEADBEEF);
    chk("st_if_data", IF_RdData, 32'd3);
    step(0, 0, 32'h0, 1, 0, 32'h20, 32'h0, 0);
    chk("ld_memwrite", Mem_MemWrite, 0);
    chk("ld_no_st_valid", MEM_RdValid, 0);
    chk("ld_mem_gnt", MEM_Gnt, 1);
    step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    chk("ld_valid", MEM_RdValid, 1);
    chk("ld_data", MEM_RdData, 32'hDEADBEEF);
    chk("ld_stall", MEM_Stall, 0);
    // Flush
    step(0, 1, 32'h14, 0, 0, 32'h0, 32'h0, 0);
    chk("fl_gnt", IF_Gnt, 1);
    step(0, 1, 32'h18, 0, 0, 32'h0, 32'h0, 1);
    chk("fl_valid", IF_RdValid, 0);
    chk("fl_data", IF_RdData, 32'd0);
    chk("fl_gnt2", IF_Gnt, 1);
    step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    chk("fl_after_valid", IF_RdValid, 1);
    chk("fl_after_data", IF_RdData, 32'd6);
    // Reset mid-read
    step(0, 1, 32'h1C, 0, 0, 32'h0, 32'h0, 0);
    chk("rm_gnt", IF_Gnt, 1);
    step(1, 1, 32'h1C, 0, 0, 32'h0, 32'h0, 0);
    chk("rm_valid", IF_RdValid, 0);
    chk("rm_gnt_rst", IF_Gnt, 0);
    chk("rm_addr_rst", Mem_Address, 32'h0);
    step(0, 1, 32'h24, 0, 0, 32'h0, 32'h0, 0);
    chk("rm_after_valid", IF_RdValid, 0);
    chk("rm_after_gnt", IF_Gnt, 1);
    step(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    chk("rm_resume_data", IF_RdData, 32'd9);
    // Sustained conflict
    for (int i = 0; i < 8; i++) begin
      logic exp_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (i % 4) == 3;
`else
      exp_if = 1'b0;
`endif
      step(0, 1, 32'h30, 1, 0, 32'h50, 32'h0, 0);
      chk($sformatf("sv%0d_if_gnt", i), IF_Gnt, exp_if);
      chk($sformatf("sv%0d_mem_gnt", i), MEM_Gnt, !exp_if);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
